key_pulse: RTL
==============

# key_pulse

Input-conditioning stage for the tug-of-war game. It takes the two raw player push-buttons, synchronises them to `clk`, and debounces each one. It then emits a single-cycle press pulse per key. These pulses drive the `L`/`R` inputs of every light FSM on the playfield, so one physical press advances play by exactly one step.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised samples at the new level needed to accept a press or release; legal range ≥ 1.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0); one clock, no other reset source.
- `keyL_n`  in  1  raw left button, active-low, asynchronous to `clk`.
- `keyR_n`  in  1  raw right button, active-low, asynchronous to `clk`.
- `L`  out  1  one-cycle pulse on each accepted left press.
- `R`  out  1  one-cycle pulse on each accepted right press.
- `heldL`  out  1  debounced left level, 1 = pressed.
- `heldR`  out  1  debounced right level, 1 = pressed.

## Operation
- Per key, independent identical channels; no cross-coupling or arbitration. Both keys may pulse in the same cycle; the downstream FSMs resolve it.
- Per-channel pipeline: two-flop synchroniser `s1` → `s2` (pressed = `~keyX_n`), then the debounce FSM.
- Debounce FSM states: RELEASED, PRESSED; `heldX` = (state == PRESSED).
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Each edge, if `s2` disagrees with state:
    - if `cnt == DEBOUNCE_CYCLES-1`, flip state and clear `cnt`;
    - otherwise increment `cnt`.
  - Any edge where `s2` agrees with state clears `cnt`, so glitches shorter than DEBOUNCE_CYCLES samples are discarded.
- Pulse: `X` is registered and set to 1 exactly on the edge where state goes RELEASED→PRESSED; 0 on every other edge.
- Release (PRESSED→RELEASED) gives no pulse. A held key gives one pulse only; a new pulse requires an accepted release first.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; no wrap.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - `s1`, `s2` = not-pressed;
  - state = RELEASED;
  - `cnt` = 0;
  - `L` = `R` = `heldL` = `heldR` = 0.
- Let E0 be the first edge sampling a stable pressed level:
  - `s2` is pressed after E0+1;
  - state flips at edge E0+1+DEBOUNCE_CYCLES;
  - `X` is high for exactly the cycle between edges E0+1+D and E0+2+D.
- Release is symmetric: `heldX` falls at E0'+1+D.
- Reset asserted mid-count or mid-press aborts everything immediately.
- A key still held when reset deasserts is treated as a fresh press and pulses after D+2 edges.

## Configuration
- Macro `KEY_DEBOUNCE_EN`.
- Defined: counter-based debounce as above.
- Undefined:
  - counter logic is removed;
  - state follows `s2` directly, one edge later;
  - behaviour and latency are identical to DEBOUNCE_CYCLES = 1;
  - the parameter is ignored.

## Structure
- Package `tug_pkg`: `key_state_t` enum {RELEASED, PRESSED} and `DEBOUNCE_CYCLES_DEFAULT` constant, shared with other game blocks.
- Sub-module `key_conditioner`: one channel (synchroniser + debounce FSM + pulse register), parameterised by DEBOUNCE_CYCLES.
- `key_pulse` instantiates it twice, left and right, and contains no other logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 with `KEY_DEBOUNCE_EN` defined, unless stated.
- Reset: hold `reset`=0 for 2 cycles with keys released → all outputs 0. `keyL_n` low at E0 → `L` high only in the cycle after E0+5; `heldL`=1 from E0+5.
- Bounce: `keyR_n` low for 3 samples, high for 1, then low steadily from E1 → no early pulse; single `R` pulse after E1+5.
- Hold: `keyL_n` low for 40 cycles → exactly one `L` pulse. Release → `heldL` falls 5 edges after the first released sample, with no pulse.
- Simultaneous: both keys low at the same edge → `L` and `R` pulse in the same cycle, once each.
- Reset mid-operation: assert `reset` at count 2, and again while PRESSED → outputs clear at once. With the key still held at deassert → one new pulse after D+2 edges.
- Macro off: `keyL_n` low at E0 → `L` pulse in the cycle after E0+2. A single-sample glitch passes as a pulse.

Source files
------------

// File: rtl/tug_pkg.sv
// tug_pkg -- shared types and constants for the tug-of-war game blocks.
//   key_state_t             : debounced key level (RELEASED / PRESSED)
//   DEBOUNCE_CYCLES_DEFAULT : default number of stable samples for a key edge
package tug_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/key_pulse_if.sv
// key_pulse_if -- player-key bundle between the button pins and the game.
//   keyL_n, keyR_n : raw active-low push-buttons (asynchronous)
//   L, R           : one-cycle press pulses
//   heldL, heldR   : debounced key levels, 1 = pressed
// Modports: master drives the keys and observes the outputs;
//           slave is the conditioning stage (key_pulse).
interface key_pulse_if;
  logic keyL_n;
  logic keyR_n;
  logic L;
  logic R;
  logic heldL;
  logic heldR;

  modport master (
    output keyL_n, keyR_n,
    input  L, R, heldL, heldR
  );

  modport slave (
    input  keyL_n, keyR_n,
    output L, R, heldL, heldR
  );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner -- one key channel: 2-flop synchroniser, debounce FSM and
// a registered single-cycle press pulse.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   key_n   : raw active-low button
//   pulse   : 1 for one cycle when a press is accepted
//   held    : debounced level, 1 = pressed
// Build option: KEY_DEBOUNCE_EN selects the counter-based debounce; without
// it the state follows the synchronised key one edge later and
// DEBOUNCE_CYCLES is not used by the datapath.
module key_conditioner
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pulse,
  output logic held
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic       s1;
  logic       s2;
  key_state_t state;

  // Synchroniser carries the pressed sense (inverted pin level).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt counts consecutive samples disagreeing with state; any agreeing
  // sample restarts it, so short glitches never reach LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s2 != (state == PRESSED)) begin
        if (cnt == LAST) begin
          state <= (state == PRESSED) ? RELEASED : PRESSED;
          cnt   <= '0;
          pulse <= (state == RELEASED);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
      pulse <= 1'b0;
    end else begin
      state <= s2 ? PRESSED : RELEASED;
      pulse <= s2 && (state == RELEASED);
    end
  end
`endif

  assign held = (state == PRESSED);

endmodule

// File: rtl/key_pulse.sv
// key_pulse -- input conditioning for the two player buttons. Each key is
// synchronised, debounced and turned into a one-cycle press pulse that
// drives the L/R inputs of the light FSMs.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   kp    : key_pulse_if.slave (keyL_n/keyR_n in; L/R/heldL/heldR out)
// Build option: KEY_DEBOUNCE_EN enables counter-based debouncing
// (DEBOUNCE_CYCLES samples); otherwise behaves as DEBOUNCE_CYCLES = 1.
module key_pulse
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  key_pulse_if.slave  kp
);

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .reset (reset),
    .key_n (kp.keyL_n),
    .pulse (kp.L),
    .held  (kp.heldL)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .reset (reset),
    .key_n (kp.keyR_n),
    .pulse (kp.R),
    .held  (kp.heldR)
  );

endmodule
